aes_sub_sched: RTL and testbench



---
 rtl/aes_pkg.sv | 10 +
 rtl/aes_sbox.sv | 18 +
 rtl/aes_sub_rr_arb.sv | 20 ++
 rtl/aes_sub_sched.sv | 90 +++++++++
 tb/tb_aes_sub_sched.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared owner/state encodings, byte counts and byte-select helper
package aes_pkg;
  typedef enum logic {OWN_ST = 1'b0, OWN_KS = 1'b1} owner_e;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  localparam int STATE_BYTES = 16;
  localparam int WORD_BYTES = 4;
  function automatic logic [7:0] byte_sel(input logic [127:0] w, input int idx);
    return w[127 - 8*idx -: 8];
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward Sbox lookup
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [10:0] idx;
  assign idx = {~a, 3'b000};
  assign y = T[idx +: 8];
endmodule

// File: rtl/aes_sub_rr_arb.sv
// aes_sub_rr_arb: two-way round-robin arbiter between state and key-schedule requesters
module aes_sub_rr_arb
  import aes_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  logic   st_req,
  input  logic   ks_req,
  output logic   gnt,
  output owner_e owner
);
  owner_e last_owner;
  assign gnt = en & (st_req | ks_req);
  assign owner = (st_req & ks_req) ? owner_e'(last_owner == OWN_ST) : owner_e'(ks_req);
  // remember the most recent winner so a tie goes to the other side
  always_ff @(posedge clk)
    if (!rst_n) last_owner <= OWN_ST;
    else if (gnt) last_owner <= owner;
endmodule

// File: rtl/aes_sub_sched.sv
// aes_sub_sched: shares NUM_SBOX Sbox instances between SubBytes and SubWord requesters
module aes_sub_sched
  import aes_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st_req,
  input  logic [127:0] st_in,
  output logic         st_gnt,
  output logic         st_done,
  output logic [127:0] st_out,
  input  logic         ks_req,
  input  logic [31:0]  ks_in,
  output logic         ks_gnt,
  output logic         ks_done,
  output logic [31:0]  ks_out,
  output logic         busy
);
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad
    $error("aes_sub_sched: NUM_SBOX must be 1, 2 or 4");
  end
  localparam logic [3:0] ST_LAST = 4'(STATE_BYTES / NUM_SBOX - 1);
  localparam logic [3:0] KS_LAST = 4'(WORD_BYTES / NUM_SBOX - 1);
  state_e       state, state_n;
  owner_e       owner, own_n;
  logic [3:0]   chunk;
  logic [127:0] work, res, res_n;
  logic [7:0]   sb_in [NUM_SBOX];
  logic [7:0]   sb_out [NUM_SBOX];
  logic         gnt, last;
  aes_sub_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .st_req(st_req),
    .ks_req(ks_req),
    .gnt   (gnt),
    .owner (own_n)
  );
  assign busy = state == BUSY;
  assign last = busy && chunk == (owner == OWN_KS ? KS_LAST : ST_LAST);
  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    assign sb_in[g] = byte_sel(work, int'(chunk) * NUM_SBOX + g);
    aes_sbox u_sbox (.a(sb_in[g]), .y(sb_out[g]));
  end
  // drop this chunk's Sbox outputs into their byte slots of the result
  always_comb begin
    res_n = res;
    for (int i = 0; i < NUM_SBOX; i++) res_n[127 - 8*(int'(chunk) * NUM_SBOX + i) -: 8] = sb_out[i];
  end
  // state register
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  // IDLE -> BUSY on a grant, BUSY -> IDLE after the last chunk
  always_comb begin
    state_n = state;
    if (gnt) state_n = BUSY;
    else if (last) state_n = IDLE;
  end
  // capture, chunk sequencing, result publication and handshake pulses
  always_ff @(posedge clk)
    if (!rst_n) begin
      owner   <= OWN_ST;
      chunk   <= '0;
      work    <= '0;
      res     <= '0;
      st_out  <= '0;
      ks_out  <= '0;
      st_gnt  <= 1'b0;
      ks_gnt  <= 1'b0;
      st_done <= 1'b0;
      ks_done <= 1'b0;
    end else begin
      st_gnt  <= gnt && own_n == OWN_ST;
      ks_gnt  <= gnt && own_n == OWN_KS;
      st_done <= last && owner == OWN_ST;
      ks_done <= last && owner == OWN_KS;
      if (gnt) begin
        owner <= own_n;
        chunk <= '0;
        work  <= own_n == OWN_KS ? {ks_in, 96'b0} : st_in;
      end else if (busy) begin
        res   <= res_n;
        chunk <= chunk + 4'd1;
        if (last && owner == OWN_ST) st_out <= res_n;
        if (last && owner == OWN_KS) ks_out <= res_n[127:96];
      end
    end
endmodule

// File: tb/tb_aes_sub_sched.sv
// tb_aes_sub_sched: table-driven and directed checks of aes_sub_sched at NUM_SBOX 4, 2, 1
module tb_aes_sub_sched;
  typedef struct {
    logic         ks;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  localparam logic [127:0] V1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1 = 128'h638293c31bfc33f5c4eeacea4bc12816;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] st_in;
  logic [31:0]  ks_in;
  logic [2:0]   st_req, ks_req, st_gnt, st_done, ks_gnt, ks_done, busy;
  logic [127:0] st_out [3];
  logic [31:0]  ks_out [3];
  logic [127:0] mst [3];
  logic [31:0]  mks [3];
  vec_t         vt [3];
  int           n_cmp = 0;
  int           n_err = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_sub_sched #(.NUM_SBOX(g == 0 ? 4 : g == 1 ? 2 : 1)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .st_req (st_req[g]),
      .st_in  (st_in),
      .st_gnt (st_gnt[g]),
      .st_done(st_done[g]),
      .st_out (st_out[g]),
      .ks_req (ks_req[g]),
      .ks_in  (ks_in),
      .ks_gnt (ks_gnt[g]),
      .ks_done(ks_done[g]),
      .ks_out (ks_out[g]),
      .busy   (busy[g])
    );
  end
  function automatic int ns(input int k);
    return k == 0 ? 4 : k == 1 ? 2 : 1;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic wait_done(input int k, input logic ks, output int lat);
    lat = 0;
    while (!(ks ? ks_done[k] : st_done[k]) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_vec(input int k, input vec_t v);
    int lat;
    @(negedge clk);
    if (v.ks) begin ks_in = v.din[127:96]; ks_req[k] = 1'b1; end
    else begin st_in = v.din; st_req[k] = 1'b1; end
    @(negedge clk);
    chk($sformatf("gnt k%0d ks%0d", k, v.ks), v.ks ? ks_gnt[k] : st_gnt[k], 1);
    chk($sformatf("busy k%0d ks%0d", k, v.ks), busy[k], 1);
    wait_done(k, v.ks, lat);
    st_req[k] = 1'b0;
    ks_req[k] = 1'b0;
    chk($sformatf("latency k%0d ks%0d", k, v.ks), lat, v.ks ? 4 / ns(k) : 16 / ns(k));
    if (v.ks) begin
      chk($sformatf("ks_out k%0d", k), {ks_out[k], 96'b0}, v.exp);
      chk($sformatf("st_out kept k%0d", k), st_out[k], mst[k]);
      mks[k] = v.exp[127:96];
    end else begin
      chk($sformatf("st_out k%0d", k), st_out[k], v.exp);
      chk($sformatf("ks_out kept k%0d", k), ks_out[k], mks[k]);
      mst[k] = v.exp;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int lat;
    bit seen;
    st_req = '0;
    ks_req = '0;
    st_in = '0;
    ks_in = '0;
    vt[0] = '{1'b0, V1, R1};
    vt[1] = '{1'b1, {32'hcf4f3c09, 96'b0}, {32'h8a84eb01, 96'b0}};
    vt[2] = '{1'b0, 128'b0, {16{8'h63}}};
    for (int k = 0; k < 3; k++) begin mst[k] = '0; mks[k] = '0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset flags k%0d", k), {busy[k], st_gnt[k], st_done[k], ks_gnt[k], ks_done[k]}, 0);
      chk($sformatf("reset st_out k%0d", k), st_out[k], 0);
      chk($sformatf("reset ks_out k%0d", k), ks_out[k], 0);
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 3; i++) run_vec(k, vt[i]);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // tie from reset: KS first, then KS re-requests against held ST -> ST wins
    @(negedge clk);
    st_in = V1;
    ks_in = 32'hcf4f3c09;
    st_req[0] = 1'b1;
    ks_req[0] = 1'b1;
    @(negedge clk);
    chk("tie1 ks_gnt", ks_gnt[0], 1);
    chk("tie1 st_gnt", st_gnt[0], 0);
    @(negedge clk);
    chk("tie1 ks_done", ks_done[0], 1);
    chk("tie1 ks_out", ks_out[0], 32'h8a84eb01);
    @(negedge clk);
    chk("tie2 st_gnt", st_gnt[0], 1);
    chk("tie2 ks_gnt", ks_gnt[0], 0);
    wait_done(0, 1'b0, lat);
    st_req[0] = 1'b0;
    chk("tie2 latency", lat, 4);
    chk("tie2 st_out", st_out[0], R1);
    @(negedge clk);
    chk("held ks served", ks_gnt[0], 1);
    @(negedge clk);
    chk("held ks done", ks_done[0], 1);
    ks_req[0] = 1'b0;
    chk("held ks_out", ks_out[0], 32'h8a84eb01);
    // back-to-back ST with no idle gap beyond the done cycle
    @(negedge clk);
    st_in = V1;
    st_req[0] = 1'b1;
    @(negedge clk);
    chk("b2b gnt1", st_gnt[0], 1);
    wait_done(0, 1'b0, lat);
    chk("b2b lat1", lat, 4);
    chk("b2b out1", st_out[0], R1);
    st_in = '0;
    @(negedge clk);
    chk("b2b gnt2", st_gnt[0], 1);
    wait_done(0, 1'b0, lat);
    st_req[0] = 1'b0;
    chk("b2b lat2", lat, 4);
    chk("b2b out2", st_out[0], {16{8'h63}});
    // reset two cycles into an ST operation aborts silently
    @(negedge clk);
    st_in = V1;
    st_req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    st_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", busy[0], 0);
    chk("abort st_out", st_out[0], 0);
    chk("abort ks_out", ks_out[0], 0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= st_done[0];
    end
    chk("abort no st_done", seen, 0);
    for (int k = 0; k < 3; k++) begin mst[k] = '0; mks[k] = '0; end
    run_vec(0, vt[0]);
    run_vec(0, vt[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
